// File: rtl/lora_chirp_phase_gen_pkg.sv
// Shared constants and FSM state type for the LoRa chirp phase generator.
// Define CHIRP_PHASE_RESET_EN to zero the phase on every symbol accept.
package lora_chirp_phase_gen_pkg;

  localparam int PRECISION = 25;
  localparam int SF_MAX    = 12;
  localparam int OSR_LOG2  = 2;
  localparam int SF_MIN    = 6;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/lora_chirp_inc.sv
// Per-sample phase increment of a linear chirp: maps the frequency word,
// the latched spreading factor and direction to a PRECISION-bit step.
module lora_chirp_inc #(
  parameter int PRECISION = lora_chirp_phase_gen_pkg::PRECISION,
  parameter int SF_MAX    = lora_chirp_phase_gen_pkg::SF_MAX,
  parameter int OSR_LOG2  = lora_chirp_phase_gen_pkg::OSR_LOG2
) (
  input  logic [SF_MAX+OSR_LOG2-1:0] fw,
  input  logic [3:0]                 sf_l,
  input  logic                       down,
  output logic [PRECISION-1:0]       inc
);

  logic [7:0]           sh;
  logic [PRECISION-1:0] fw_x;
  logic [PRECISION-1:0] mag;
  logic [PRECISION-1:0] off;
  logic [PRECISION-1:0] raw;

  // Half the band in phase-per-sample; centres the sweep on DC.
  assign off  = PRECISION'(1) << (PRECISION - 1 - OSR_LOG2);
  assign sh   = 8'(PRECISION - 2 * OSR_LOG2) - {4'b0, sf_l};
  assign fw_x = PRECISION'(fw);
  assign mag  = fw_x << sh;
  assign raw  = mag - off;
  assign inc  = down ? -raw : raw;

endmodule

// File: rtl/lora_chirp_phase_gen.sv
// LoRa chirp phase accumulator: one symbol per handshake, one angle per sample.
// Define CHIRP_PHASE_RESET_EN to clear the phase on every symbol accept.
module lora_chirp_phase_gen #(
  parameter int PRECISION = lora_chirp_phase_gen_pkg::PRECISION,
  parameter int SF_MAX    = lora_chirp_phase_gen_pkg::SF_MAX,
  parameter int OSR_LOG2  = lora_chirp_phase_gen_pkg::OSR_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           sf,
  input  logic [SF_MAX-1:0]    sym,
  input  logic                 sym_down,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  output logic [PRECISION-1:0] angle,
  output logic                 angle_valid,
  input  logic                 out_ready,
  output logic                 sym_done
);

  import lora_chirp_phase_gen_pkg::*;

  localparam int CW = SF_MAX + OSR_LOG2;

  state_t               state;
  state_t               state_nx;
  logic [3:0]           sf_l;
  logic [3:0]           sf_c;
  logic [SF_MAX-1:0]    sym_l;
  logic [SF_MAX-1:0]    smask;
  logic                 down_l;
  logic [CW-1:0]        n;
  logic [CW-1:0]        lmask;
  logic [CW-1:0]        fw;
  logic [PRECISION-1:0] acc;
  logic [PRECISION-1:0] acc_nx;
  logic [PRECISION-1:0] inc;
  logic                 hs;
  logic                 last;
  logic                 accept;

  always_comb begin
    sf_c = sf;
    if (sf < 4'(SF_MIN)) sf_c = 4'(SF_MIN);
    if (sf > 4'(SF_MAX)) sf_c = 4'(SF_MAX);
  end

  assign smask = (SF_MAX'(1) << sf_c) - SF_MAX'(1);

  // L-1 mask; the shift overflows to 0 at SF_MAX and wraps to all ones.
  assign lmask = (CW'(1) << (sf_l + 4'(OSR_LOG2))) - CW'(1);
  assign last  = (n == lmask);
  assign fw    = ((CW'(sym_l) << OSR_LOG2) + n) & lmask;

  assign hs     = (state == RUN) && out_ready;
  assign accept = sym_valid && sym_ready;

  lora_chirp_inc #(
    .PRECISION (PRECISION),
    .SF_MAX    (SF_MAX),
    .OSR_LOG2  (OSR_LOG2)
  ) u_inc (
    .fw   (fw),
    .sf_l (sf_l),
    .down (down_l),
    .inc  (inc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (hs && last && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sym_ready   = !rst && ((state == IDLE) || (hs && last));
    angle_valid = (state == RUN);
    sym_done    = !rst && hs && last;
  end

  always_comb begin
    acc_nx = acc;
    if (hs) acc_nx = acc + inc;
`ifdef CHIRP_PHASE_RESET_EN
    if (accept) acc_nx = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sf_l   <= '0;
      sym_l  <= '0;
      down_l <= 1'b0;
      n      <= '0;
      acc    <= '0;
      angle  <= '0;
    end else begin
      if (accept) begin
        sf_l   <= sf_c;
        sym_l  <= sym & smask;
        down_l <= sym_down;
        n      <= '0;
      end else if (hs) begin
        n <= last ? '0 : n + CW'(1);
      end
      acc <= acc_nx;
      // After the final sample with no follow-on symbol, angle keeps it.
      if (accept || (hs && !last)) angle <= acc_nx;
    end
  end

endmodule

// File: tb/tb_lora_chirp_phase_gen.sv
// Directed bench for lora_chirp_phase_gen at sf 7 / sf 6.
// Phase-continuous build (CHIRP_PHASE_RESET_EN undefined).
module tb_lora_chirp_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sf;
  logic [11:0] sym;
  logic        sym_down;
  logic        sym_valid;
  logic        sym_ready;
  logic [24:0] angle;
  logic        angle_valid;
  logic        out_ready;
  logic        sym_done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [24:0] model_acc;
  logic [24:0] a0;
  logic [24:0] a1;

  always #5 clk = ~clk;

  lora_chirp_phase_gen dut (
    .clk         (clk),
    .rst         (rst),
    .sf          (sf),
    .sym         (sym),
    .sym_down    (sym_down),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .angle       (angle),
    .angle_valid (angle_valid),
    .out_ready   (out_ready),
    .sym_done    (sym_done)
  );

  function automatic logic [24:0] ref_inc(input int sfe, input int y,
                                          input int n, input bit d);
    int          l;
    int          fw;
    logic [24:0] v;
    l  = 1 << (sfe + 2);
    fw = (y * 4 + n) % l;
    v  = 25'(fw << (21 - sfe)) - 25'(4194304);
    if (d) v = -v;
    return v;
  endfunction

  task automatic accept(input logic [3:0] s, input logic [11:0] y,
                        input bit d);
    @(negedge clk);
    sf = s; sym = y; sym_down = d; sym_valid = 1'b1;
    #1;
    vectors++;
    if (sym_ready !== 1'b1 || angle_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL accept: ready=%b valid=%b, want ready=1 valid=0",
               sym_ready, angle_valid);
    end
    @(posedge clk);
    #1;
    sym_valid = 1'b0; sf = '0; sym = '0; sym_down = 1'b0;
  endtask

  task automatic stream(input int sfe, input int y, input bit d,
                        input int stall_at, input bit chain,
                        output logic [24:0] s0, output logic [24:0] s1);
    int          l;
    logic [24:0] lastv;
    l = 1 << (sfe + 2);
    s0 = '0; s1 = '0; lastv = '0;
    for (int n = 0; n < l; n++) begin
      @(negedge clk);
      if (n == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          vectors++;
          if (angle !== model_acc || angle_valid !== 1'b1 ||
              sym_done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall n=%0d k=%0d: angle=%0d valid=%b done=%b, want angle=%0d valid=1 done=0",
                     n, k, angle, angle_valid, sym_done, model_acc);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      #1;
      vectors++;
      if (angle !== model_acc || angle_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sample n=%0d sym=%0d: angle=%0d valid=%b, want angle=%0d valid=1",
                 n, y, angle, angle_valid, model_acc);
      end
      vectors++;
      if (sym_done !== (n == l - 1) || sym_ready !== (n == l - 1)) begin
        miscompares++;
        $display("FAIL handshake n=%0d: done=%b ready=%b, want both %b",
                 n, sym_done, sym_ready, (n == l - 1));
      end
      if (n == 0) s0 = angle;
      if (n == 1) s1 = angle;
      lastv     = model_acc;
      model_acc = model_acc + ref_inc(sfe, y, n, d);
    end
    if (!chain) begin
      @(negedge clk);
      #1;
      vectors++;
      if (angle_valid !== 1'b0 || angle !== lastv || sym_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL idle: valid=%b angle=%0d ready=%b, want valid=0 angle=%0d ready=1",
                 angle_valid, angle, sym_ready, lastv);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sym_valid = 1'b0; out_ready = 1'b1;
    sf = '0; sym = '0; sym_down = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (angle !== '0 || angle_valid !== 1'b0 || sym_done !== 1'b0 ||
        sym_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: angle=%0d valid=%b done=%b ready=%b, want all 0",
               angle, angle_valid, sym_done, sym_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (sym_ready !== 1'b1 || angle_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: ready=%b valid=%b, want ready=1 valid=0",
               sym_ready, angle_valid);
    end
    model_acc = '0;
  endtask

  task automatic test_upchirp;
    accept(4'd7, 12'd0, 1'b0);
    stream(7, 0, 1'b0, -1, 1'b0, a0, a1);
    vectors++;
    if (a0 !== 25'd0 || a1 !== 25'd29360128) begin
      miscompares++;
      $display("FAIL upchirp_start: got %0d,%0d want 0,29360128", a0, a1);
    end
  endtask

  task automatic test_fold;
    accept(4'd7, 12'd64, 1'b0);
    stream(7, 64, 1'b0, -1, 1'b0, a0, a1);
    vectors++;
    if (a1 !== a0) begin
      miscompares++;
      $display("FAIL fold_zero_inc: s1=%0d want s0=%0d", a1, a0);
    end
  endtask

  task automatic test_masked;
    accept(4'd7, 12'd200, 1'b0);
    stream(7, 72, 1'b0, -1, 1'b0, a0, a1);
    vectors++;
    if (25'(a1 - a0) !== 25'd524288) begin
      miscompares++;
      $display("FAIL masked_inc: got %0d want 524288", 25'(a1 - a0));
    end
  endtask

  task automatic test_clamp;
    accept(4'd4, 12'd3, 1'b0);
    stream(6, 3, 1'b0, -1, 1'b0, a0, a1);
  endtask

  task automatic test_stall;
    accept(4'd7, 12'd10, 1'b0);
    stream(7, 10, 1'b0, 100, 1'b0, a0, a1);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sf = 4'd7; sym = 12'd5; sym_down = 1'b0; sym_valid = 1'b1;
    #1;
    vectors++;
    if (sym_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: ready=%b want 1", sym_ready);
    end
    @(posedge clk);
    #1;
    sym = 12'd33; sym_down = 1'b1;
    stream(7, 5, 1'b0, -1, 1'b1, a0, a1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0; sym = '0; sym_down = 1'b0;
    stream(7, 33, 1'b1, -1, 1'b0, a0, a1);
  endtask

  task automatic test_reset_mid;
    accept(4'd7, 12'd5, 1'b0);
    repeat (300) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (sym_done !== 1'b0 || sym_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_comb: done=%b ready=%b, want 0 0",
               sym_done, sym_ready);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (angle !== '0 || angle_valid !== 1'b0 || sym_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: angle=%0d valid=%b done=%b, want 0 0 0",
               angle, angle_valid, sym_done);
    end
    rst = 1'b0;
    model_acc = '0;
  endtask

  task automatic test_down;
    accept(4'd7, 12'd0, 1'b1);
    stream(7, 0, 1'b1, -1, 1'b0, a0, a1);
    vectors++;
    if (a0 !== 25'd0 || a1 !== 25'd4194304) begin
      miscompares++;
      $display("FAIL down_start: got %0d,%0d want 0,4194304", a0, a1);
    end
  endtask

  initial begin
    test_reset;
    test_upchirp;
    test_fold;
    test_masked;
    test_clamp;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_down;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
